// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// State encodings, step opcode and counter width helper.
package mul_div_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_FIN  = 2'd3
    } md_state_t;

    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    function automatic int md_cnt_w(input int rv);
        return (rv > 1) ? $clog2(rv) : 1;
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Purely combinational; the controller registers rem/result.
module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int RV = 32
) (
    input  logic          op,
    input  logic [RV-1:0] rem,
    input  logic [RV-1:0] result,
    input  logic [RV-1:0] b,
    output logic [RV-1:0] rem_nxt,
    output logic [RV-1:0] result_nxt
);

    logic [RV:0] add_sum;
    logic [RV:0] sub_t;

    // rem < b holds between steps, so bit RV of the difference is its sign
    always_comb begin
        add_sum    = {1'b0, rem} + ({1'b0, b} & {(RV+1){result[0]}});
        sub_t      = {rem, result[RV-1]} - {1'b0, b};
        rem_nxt    = add_sum[RV:1];
        result_nxt = {add_sum[0], result[RV-1:1]};
        if (op == MD_OP_DIV) begin
            if (sub_t[RV]) begin
                rem_nxt    = {rem[RV-2:0], result[RV-1]};
                result_nxt = {result[RV-2:0], 1'b0};
            end else begin
                rem_nxt    = sub_t[RV-1:0];
                result_nxt = {result[RV-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mul_div_ctl.sv
// Sequencer for the iterative multiply/divide unit.
// Owns FSM, step counter, divisor register and busy/done.
module mul_div_ctl
    import mul_div_pkg::*;
#(
    parameter int RV = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mult,
    input  logic          div,
    input  logic [RV-1:0] a,
    input  logic [RV-1:0] b,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [RV-1:0] result,
    output logic [RV-1:0] rem
);

    localparam int CW = md_cnt_w(RV);

    md_state_t     state, state_nxt;
    logic [CW-1:0] count;
    logic [RV-1:0] b_q;
    logic [RV-1:0] rem_nxt, res_nxt;
    logic          setup;
    logic          accept;
    logic          stepping;

    assign accept   = (state == MD_IDLE) && start && (mult || div) && !abort;
    assign stepping = (state == MD_MUL) || (state == MD_DIV);

    mul_div_step #(.RV(RV)) u_step (
        .op         (state == MD_DIV ? MD_OP_DIV : MD_OP_MUL),
        .rem        (rem),
        .result     (result),
        .b          (b_q),
        .rem_nxt    (rem_nxt),
        .result_nxt (res_nxt)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            MD_IDLE: begin
                if (accept) state_nxt = mult ? MD_MUL : MD_DIV;
            end
            MD_MUL, MD_DIV: begin
                if (abort) state_nxt = MD_IDLE;
                else if (!setup && count == '0) state_nxt = MD_FIN;
            end
            MD_FIN:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
        busy = (state != MD_IDLE) || accept;
        done = (state == MD_FIN) && !abort;
    end

    // first MUL/DIV cycle is a setup slot, giving a fixed RV+2 cycle op
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= MD_IDLE;
            count  <= '0;
            b_q    <= '0;
            result <= '0;
            rem    <= '0;
            setup  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                count  <= CW'(RV - 1);
                b_q    <= b;
                result <= a;
                rem    <= '0;
                setup  <= 1'b1;
            end else if (stepping) begin
                if (setup) begin
                    setup <= 1'b0;
                end else begin
                    result <= res_nxt;
                    rem    <= rem_nxt;
                    count  <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_ctl.sv
// Directed self-checking bench for mul_div_ctl at RV=32 and RV=16.
module tb_mul_div_ctl;

    logic        clk;
    logic        reset;
    logic        start, mult, div, abort;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result, rem;

    logic        start16, mult16, div16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [15:0] result16, rem16;

    int n_chk;
    int n_fail;

    mul_div_ctl #(.RV(32)) dut32 (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mult   (mult),
        .div    (div),
        .a      (a),
        .b      (b),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rem    (rem)
    );

    mul_div_ctl #(.RV(16)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .start  (start16),
        .mult   (mult16),
        .div    (div16),
        .a      (a16),
        .b      (b16),
        .abort  (1'b0),
        .busy   (busy16),
        .done   (done16),
        .result (result16),
        .rem    (rem16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // caller is positioned 1 time unit after a rising edge
    task automatic run32(input logic m, input logic d,
                         input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] er, input logic [31:0] erm,
                         input string tag);
        int   cyc;
        logic bz_ok;
        start = 1'b1; mult = m; div = d; a = aa; b = bb;
        #1;
        check({tag, ".busy_start"}, busy, 1);
        @(posedge clk); #1;
        start = 1'b0; mult = 1'b0; div = 1'b0;
        cyc = 0; bz_ok = 1'b1;
        while (!done && cyc < 100) begin
            bz_ok &= busy;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, cyc, 33);
        check({tag, ".busy_run"}, bz_ok & busy, 1);
        check({tag, ".result"}, result, er);
        check({tag, ".rem"}, rem, erm);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".busy_end"}, busy, 0);
    endtask

    task automatic run16(input logic m, input logic d,
                         input logic [15:0] aa, input logic [15:0] bb,
                         input logic [15:0] er, input logic [15:0] erm,
                         input string tag);
        int cyc;
        start16 = 1'b1; mult16 = m; div16 = d; a16 = aa; b16 = bb;
        #1;
        check({tag, ".busy_start"}, busy16, 1);
        @(posedge clk); #1;
        start16 = 1'b0; mult16 = 1'b0; div16 = 1'b0;
        cyc = 0;
        while (!done16 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, cyc, 17);
        check({tag, ".result"}, result16, er);
        check({tag, ".rem"}, rem16, erm);
        @(posedge clk); #1;
        check({tag, ".busy_end"}, busy16, 0);
    endtask

    initial begin
        int          cyc;
        int          ndone;
        logic [31:0] cap_r, cap_m;

        n_chk = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0; mult = 1'b0; div = 1'b0; abort = 1'b0;
        a = '0; b = '0;
        start16 = 1'b0; mult16 = 1'b0; div16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.result", result, 0);
        check("rst.rem", rem, 0);
        check("rst16.busy", busy16, 0);
        check("rst16.result", result16, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run32(1, 0, 32'd7, 32'd6, 32'd42, 32'd0, "mul7x6");
        run32(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h0000_0001, 32'hFFFF_FFFE, "mulmax");
        run32(0, 1, 32'd100, 32'd7, 32'd14, 32'd2, "div100_7");
        run32(0, 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "div5_0");
        run32(1, 1, 32'd7, 32'd6, 32'd42, 32'd0, "both_flags");

        // start with neither flag: ignored, result held
        start = 1'b1; a = 32'd99; b = 32'd1;
        #1;
        check("noop.busy_comb", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("noop.busy", busy, 0);
        check("noop.hold", result, 32'd42);

        // abort and start together while idle
        start = 1'b1; mult = 1'b1; abort = 1'b1; a = 32'd3; b = 32'd3;
        #1;
        check("ab_start.busy_comb", busy, 0);
        @(posedge clk); #1;
        start = 1'b0; mult = 1'b0; abort = 1'b0;
        check("ab_start.busy", busy, 0);

        // abort mid-multiply
        start = 1'b1; mult = 1'b1; a = 32'd123; b = 32'd456;
        @(posedge clk); #1;
        start = 1'b0; mult = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        abort = 1'b1;
        #1;
        check("abort.done", done, 0);
        check("abort.busy_mid", busy, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort.idle", busy, 0);
        run32(0, 1, 32'd9, 32'd3, 32'd3, 32'd0, "div9_3");

        // start held high while busy with changing operands
        start = 1'b1; mult = 1'b1; a = 32'd1000; b = 32'd1000;
        @(posedge clk); #1;
        cyc = 0; ndone = 0; cap_r = '0; cap_m = '0;
        while (ndone == 0 && cyc < 100) begin
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                ndone++;
                cap_r = result;
                cap_m = rem;
            end
        end
        start = 1'b0; mult = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("restart.latency", cyc, 33);
        check("restart.ndone", ndone, 1);
        check("restart.result", cap_r, 32'd1000000);
        check("restart.rem", cap_m, 32'd0);

        // reset mid-divide
        start = 1'b1; div = 1'b1; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; div = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid.result", result, 0);
        check("rstmid.rem", rem, 0);
        check("rstmid.busy", busy, 0);
        check("rstmid.done", done, 0);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("rstmid.nodone", ndone, 0);

        run16(1, 0, 16'd7, 16'd6, 16'd42, 16'd0, "m16_7x6");
        run16(1, 0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, "m16_max");
        run16(0, 1, 16'd1000, 16'd7, 16'd142, 16'd6, "d16_1000_7");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
